// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fb_pkg
// Brief  : Shared scan-state encoding and default geometry for the frame buffer.
// Rev    : 1.0
// ============================================================================
package fb_pkg;

    localparam int c_DATA_W     = 32;
    localparam int c_DEPTH      = 400;
    localparam int c_ADDR_W     = 9;
    localparam int c_LINE_WORDS = 20;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_FULL = 2'd1,
        S_SCAN      = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_bank_ram.sv
`default_nettype none
// ============================================================================
// Module : fb_bank_ram
// Brief  : DEPTH x DATA_W frame bank, one write port, one registered read port.
// Rev    : 1.0
// ============================================================================
module fb_bank_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 400,
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Array itself is never reset; only the read register is.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (i_re) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/frame_buffer_pingpong.sv
`default_nettype none
// ============================================================================
// Module : frame_buffer_pingpong
// Brief  : Two-bank ping-pong frame store with a scan FSM and line/frame markers.
//          FB_REPEAT_FRAME_EN: keep re-scanning the current bank until the other fills.
// Rev    : 1.0
// ============================================================================
module frame_buffer_pingpong
    import fb_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W,
    parameter int DEPTH      = c_DEPTH,
    parameter int ADDR_W     = c_ADDR_W,
    parameter int LINE_WORDS = c_LINE_WORDS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] WData,
    input  logic              WE0,
    input  logic              WE1,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              line_start,
    output logic              frame_start,
    output logic [1:0]        bank_full,
    output logic              wr_err
);

    localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_LINE_LAST = ADDR_W'(LINE_WORDS - 1);

    scan_state_t       r_state, w_state_nxt;
    logic              r_cur_bank, w_cur_bank_nxt;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
    logic [ADDR_W-1:0] r_col, w_col_nxt;
    logic [1:0]        r_bank_full, w_bank_full_nxt;
    logic [1:0]        w_release, w_we, w_re;
    logic [ADDR_W-1:0] r_wr_ptr [2];
    logic              w_scan_rd, w_wr_drop;
    logic              r_rd_valid, r_line_start, r_frame_start, r_wr_err, r_rd_sel;
    logic [DATA_W-1:0] w_bank_q [2];

    // WE0 has priority; a full bank refuses writes until the scanner releases it.
    assign w_we[0]   = WE0 & ~r_bank_full[0];
    assign w_we[1]   = WE1 & ~WE0 & ~r_bank_full[1];
    assign w_wr_drop = (WE0 & r_bank_full[0]) | (WE1 & (WE0 | r_bank_full[1]));

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            assign w_re[b] = w_scan_rd & (r_cur_bank == 1'(b));

            fb_bank_ram #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .ADDR_W (ADDR_W)
            ) u_ram (
                .clock     (clock),
                .reset_n   (reset_n),
                .i_we      (w_we[b]),
                .i_wr_addr (r_wr_ptr[b]),
                .i_wr_data (WData),
                .i_re      (w_re[b]),
                .i_rd_addr (r_rd_addr),
                .o_rd_data (w_bank_q[b])
            );
        end
    endgenerate

    always_comb begin
        w_bank_full_nxt = r_bank_full;
        for (int b = 0; b < 2; b++) begin
            if (w_we[b] && (r_wr_ptr[b] == c_LAST)) begin
                w_bank_full_nxt[b] = 1'b1;
            end
            if (w_release[b]) begin
                w_bank_full_nxt[b] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_bank_nxt = r_cur_bank;
        w_rd_addr_nxt  = r_rd_addr;
        w_col_nxt      = r_col;
        w_release      = 2'b00;
        w_scan_rd      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_WAIT_FULL;
            end
            S_WAIT_FULL: begin
                if (r_bank_full[0]) begin
                    w_cur_bank_nxt = 1'b0;
                    w_state_nxt    = S_SCAN;
                end else if (r_bank_full[1]) begin
                    w_cur_bank_nxt = 1'b1;
                    w_state_nxt    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (rd_en) begin
                    w_scan_rd = 1'b1;
                    if (r_rd_addr == c_LAST) begin
                        w_rd_addr_nxt = '0;
                        w_col_nxt     = '0;
                        // Hand over seamlessly when the other bank is already waiting.
                        if (r_bank_full[~r_cur_bank]) begin
                            w_release[r_cur_bank] = 1'b1;
                            w_cur_bank_nxt        = ~r_cur_bank;
                        end else begin
`ifdef FB_REPEAT_FRAME_EN
                            w_state_nxt = S_SCAN;
`else
                            w_release[r_cur_bank] = 1'b1;
                            w_state_nxt           = S_WAIT_FULL;
`endif
                        end
                    end else begin
                        w_rd_addr_nxt = r_rd_addr + 1'b1;
                        w_col_nxt     = (r_col == c_LINE_LAST) ? '0 : r_col + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cur_bank    <= 1'b0;
            r_rd_addr     <= '0;
            r_col         <= '0;
            r_bank_full   <= 2'b00;
            r_wr_ptr[0]   <= '0;
            r_wr_ptr[1]   <= '0;
            r_rd_valid    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_wr_err      <= 1'b0;
            r_rd_sel      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cur_bank    <= w_cur_bank_nxt;
            r_rd_addr     <= w_rd_addr_nxt;
            r_col         <= w_col_nxt;
            r_bank_full   <= w_bank_full_nxt;
            r_rd_valid    <= w_scan_rd;
            r_line_start  <= w_scan_rd & (r_col == '0);
            r_frame_start <= w_scan_rd & (r_rd_addr == '0);
            r_wr_err      <= w_wr_drop;
            for (int b = 0; b < 2; b++) begin
                if (w_we[b]) begin
                    r_wr_ptr[b] <= (r_wr_ptr[b] == c_LAST) ? '0 : r_wr_ptr[b] + 1'b1;
                end
            end
            if (w_scan_rd) begin
                r_rd_sel <= r_cur_bank;
            end
        end
    end

    // Both bank read registers hold their last word, so a registered select is enough.
    assign rd_data     = w_bank_q[r_rd_sel];
    assign rd_valid    = r_rd_valid;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign bank_full   = r_bank_full;
    assign wr_err      = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_pingpong.sv
`default_nettype none
// ============================================================================
// Module : tb_frame_buffer_pingpong
// Brief  : Self-checking bench: directed scenarios plus random traffic vs. a reference model.
// Rev    : 1.0
// ============================================================================
module tb_frame_buffer_pingpong;

    localparam int DEPTH = 400;
    localparam int LW    = 20;
`ifdef FB_REPEAT_FRAME_EN
    localparam bit c_REPEAT = 1'b1;
`else
    localparam bit c_REPEAT = 1'b0;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] WData   = '0;
    logic        WE0     = 1'b0;
    logic        WE1     = 1'b0;
    logic        rd_en   = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid, line_start, frame_start, wr_err;
    logic [1:0]  bank_full;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [31:0] m_mem [2][DEPTH];
    int          m_ptr [2];
    logic [1:0]  m_full;
    int          m_state;   // 0 idle, 1 waiting for a full bank, 2 scanning
    int          m_cur;
    int          m_addr;
    logic        e_valid, e_line, e_frame, e_err;
    logic [31:0] e_data;

    frame_buffer_pingpong dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .WData       (WData),
        .WE0         (WE0),
        .WE1         (WE1),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .line_start  (line_start),
        .frame_start (frame_start),
        .bank_full   (bank_full),
        .wr_err      (wr_err)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr[0] = 0; m_ptr[1] = 0;
        m_full   = 2'b00;
        m_state  = 0; m_cur = 0; m_addr = 0;
        e_valid  = 1'b0; e_line = 1'b0; e_frame = 1'b0; e_err = 1'b0; e_data = '0;
    endtask

    task automatic model_edge(input bit we0, input bit we1, input bit rden, input logic [31:0] wd);
        logic [1:0] nf;
        nf      = m_full;
        e_valid = (m_state == 2) && rden;
        e_line  = 1'b0;
        e_frame = 1'b0;
        if (e_valid) begin
            e_data  = m_mem[m_cur][m_addr];
            e_line  = (m_addr % LW) == 0;
            e_frame = (m_addr == 0);
        end
        e_err = (we0 && m_full[0]) || (we1 && (we0 || m_full[1]));
        for (int b = 0; b < 2; b++) begin
            bit wr;
            wr = (b == 0) ? (we0 && !m_full[0]) : (we1 && !we0 && !m_full[1]);
            if (wr) begin
                m_mem[b][m_ptr[b]] = wd;
                m_ptr[b]++;
                if (m_ptr[b] == DEPTH) begin
                    m_ptr[b] = 0;
                    nf[b]    = 1'b1;
                end
            end
        end
        case (m_state)
            0: m_state = 1;
            1: begin
                if (m_full[0]) begin m_cur = 0; m_state = 2; end
                else if (m_full[1]) begin m_cur = 1; m_state = 2; end
            end
            default: begin
                if (rden) begin
                    if (m_addr == DEPTH - 1) begin
                        m_addr = 0;
                        if (m_full[1 - m_cur]) begin
                            nf[m_cur] = 1'b0;
                            m_cur     = 1 - m_cur;
                        end else if (!c_REPEAT) begin
                            nf[m_cur] = 1'b0;
                            m_state   = 1;
                        end
                    end else begin
                        m_addr++;
                    end
                end
            end
        endcase
        m_full = nf;
    endtask

    // One clock: drive at the falling edge, model at the rising edge, check at the next fall.
    task automatic step(input bit we0, input bit we1, input bit rden, input logic [31:0] wd);
        WE0 = we0; WE1 = we1; rd_en = rden; WData = wd;
        @(posedge clock);
        model_edge(we0, we1, rden, wd);
        @(negedge clock);
        chk_eq("rd_valid", rd_valid, e_valid);
        chk_eq("line_start", line_start, e_line);
        chk_eq("frame_start", frame_start, e_frame);
        chk_eq("bank_full", bank_full, m_full);
        chk_eq("wr_err", wr_err, e_err);
        if (e_valid) chk_eq("rd_data", rd_data, e_data);
    endtask

    task automatic apply_reset(input string tag);
        WE0 = 1'b0; WE1 = 1'b0; rd_en = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_eq({tag, "_rd_data"}, rd_data, 32'h0);
        chk_eq({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk_eq({tag, "_line"}, line_start, 1'b0);
        chk_eq({tag, "_frame"}, frame_start, 1'b0);
        chk_eq({tag, "_full"}, bank_full, 2'b00);
        chk_eq({tag, "_err"}, wr_err, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int k, nl, nv, nfs;
        logic [31:0] first_word;
        #2;

        // Single frame through bank 0, plus a write attempted into the full bank
        apply_reset("rst0");
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, i);
        chk_eq("t1_full_after_fill", bank_full, 2'b01);
        step(1, 0, 0, 32'h0000_0BAD);
        chk_eq("t4_drop_err", wr_err, 1'b1);
        k = 0; nl = 0;
        for (int c = 0; c < DEPTH + 10 && k < DEPTH; c++) begin
            step(0, 0, 1, 0);
            if (rd_valid) begin
                chk_eq("t1_word", rd_data, k);
                chk_eq("t1_line", line_start, (k % LW) == 0);
                chk_eq("t1_frame", frame_start, k == 0);
                if (line_start) nl++;
                k++;
            end
        end
        chk_eq("t1_word_count", k, DEPTH);
        chk_eq("t1_line_count", nl, DEPTH / LW);
        chk_eq("t1_full_after_scan", bank_full, c_REPEAT ? 2'b01 : 2'b00);
        step(0, 0, 1, 0);
        chk_eq("t6_next_valid", rd_valid, c_REPEAT);
        chk_eq("t6_next_frame", frame_start, c_REPEAT);

        // Simultaneous writes, then ping-pong handover with no gap
        apply_reset("rst1");
        step(1, 1, 0, 32'h0000_DEAD);
        chk_eq("t3_dual_err", wr_err, 1'b1);
        step(0, 0, 0, 0);
        chk_eq("t3_err_pulse", wr_err, 1'b0);
        for (int i = 1; i < DEPTH; i++) step(1, 0, 0, 32'h1000 + i);
        chk_eq("t3_bank0_full", bank_full, 2'b01);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 0, 32'h2000 + i);
        chk_eq("t3_bank1_not_full", bank_full, 2'b01);
        step(0, 1, 0, 32'h2000 + DEPTH - 1);
        chk_eq("t3_bank1_full", bank_full, 2'b11);
        nv = 0; nfs = 0; first_word = '0;
        for (int c = 0; c < 2 * DEPTH; c++) begin
            step(0, 0, 1, 0);
            if (rd_valid) begin
                if (nv == 0) first_word = rd_data;
                if (nv == DEPTH) chk_eq("t2_bank1_word0", rd_data, 32'h2000);
                if (frame_start) nfs++;
                nv++;
            end
        end
        chk_eq("t2_valid_count", nv, 2 * DEPTH);
        chk_eq("t2_frame_count", nfs, 2);
        chk_eq("t3_bank0_word0", first_word, 32'h0000_DEAD);

        // Reset in the middle of a scan, then refill
        apply_reset("rst2");
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 32'h3000 + i);
        step(0, 0, 0, 0);
        for (int c = 0; c < 150; c++) step(0, 0, 1, 0);
        chk_eq("t5_mid_word", rd_data, 32'h3000 + 149);
        apply_reset("t5_async");
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 32'h4000 + i);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk_eq("t5_restart_frame", frame_start, 1'b1);
        chk_eq("t5_restart_word", rd_data, 32'h4000);

        // Random traffic against the model
        apply_reset("rst3");
        for (int c = 0; c < 6000; c++) begin
            int r;
            bit we0, we1;
            r   = $urandom_range(0, 15);
            we0 = (r < 6) || (r == 15);
            we1 = (r >= 6 && r < 12) || (r == 15);
            step(we0, we1, $urandom_range(0, 3) != 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
